// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package inst_loader_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [31:0] NOP_INST  = 32'h0000_0000;
  localparam int          MAX_WORDS = 64;

endpackage

// File: rtl/inst_ram.sv
// Instruction RAM: one synchronous write port, one asynchronous read port, zero at power-up.
module inst_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_loader.sv
// Byte-stream instruction loader: assembles little-endian words into the RAM and holds the CPU meanwhile.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_start,
  input  logic [LEN_W-1:0]  ld_len,
  input  logic              ld_abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] inst,
  output logic              cpu_hold,
  output logic              ld_done,
  output logic              ld_err
);

  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        byte_cnt;
  logic [23:0]       shreg;
  logic              accept;
  logic              last_word;
  logic              len_ok;
  logic              we;
  logic [DATA_W-1:0] rdata;

  assign byte_ready = (state == S_LOAD);
  assign cpu_hold   = (state != S_IDLE);
  // An abort wins over a byte presented in the same cycle.
  assign accept     = byte_ready & byte_valid & ~ld_abort;
  // Gated by rst_n so a reset edge can never commit a half-finished load's word.
  assign we         = accept & (byte_cnt == 2'd3) & rst_n;
  assign last_word  = (LEN_W'(wr_addr) == len - LEN_W'(1));
  assign len_ok     = (ld_len != '0) && (ld_len <= LEN_W'(MAX_WORDS));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ld_done  <= 1'b0;
      ld_err   <= 1'b0;
      byte_cnt <= 2'd0;
      wr_addr  <= '0;
    end else begin
      ld_done <= 1'b0;
      ld_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ld_start) begin
            if (len_ok) begin
              len      <= ld_len;
              wr_addr  <= '0;
              byte_cnt <= 2'd0;
              state    <= S_LOAD;
            end else begin
              ld_err <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (ld_abort) begin
            state  <= S_IDLE;
            ld_err <= 1'b1;
          end else if (accept) begin
            if (byte_cnt == 2'd3) begin
              byte_cnt <= 2'd0;
              wr_addr  <= wr_addr + 1'b1;
              if (last_word) begin
                state   <= S_DONE;
                ld_done <= 1'b1;
              end
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              shreg    <= {byte_data, shreg[23:8]};
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  inst_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_addr),
    .wdata(DATA_W'({byte_data, shreg})),
    .raddr(a),
    .rdata(rdata)
  );

  assign inst = cpu_hold ? DATA_W'(NOP_INST) : rdata;

endmodule
